// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded control and operands from ID plus registered EX view.
// master drives the ID side (upstream), slave is the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        PC_ctrl_i;
  logic [4:0]        EX_ctrl_i;
  logic [1:0]        MEM_ctrl_i;
  logic [1:0]        WB_ctrl_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [4:0]        rs_addr_i;
  logic [4:0]        rt_addr_i;
  logic [4:0]        rd_addr_i;

  logic [4:0]        EX_ctrl_o;
  logic [1:0]        MEM_ctrl_o;
  logic [1:0]        WB_ctrl_o;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] imm_o;
  logic [4:0]        rs_addr_o;
  logic [4:0]        rt_addr_o;
  logic [4:0]        rd_addr_o;
  logic [1:0]        PC_ctrl_o;
  logic              stall_o;
  logic              busy_o;

  modport master (
    output PC_ctrl_i, EX_ctrl_i,
    output MEM_ctrl_i, WB_ctrl_i,
    output rs_data_i, rt_data_i, imm_i,
    output rs_addr_i, rt_addr_i, rd_addr_i,
    input  EX_ctrl_o, MEM_ctrl_o, WB_ctrl_o,
    input  rs_data_o, rt_data_o, imm_o,
    input  rs_addr_o, rt_addr_o, rd_addr_o,
    input  PC_ctrl_o, stall_o, busy_o
  );

  modport slave (
    input  PC_ctrl_i, EX_ctrl_i,
    input  MEM_ctrl_i, WB_ctrl_i,
    input  rs_data_i, rt_data_i, imm_i,
    input  rs_addr_i, rt_addr_i, rd_addr_i,
    output EX_ctrl_o, MEM_ctrl_o, WB_ctrl_o,
    output rs_data_o, rt_data_o, imm_o,
    output rs_addr_o, rt_addr_o, rd_addr_o,
    output PC_ctrl_o, stall_o, busy_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, MUL hold and PC_ctrl gating.
// Ports: clk_i, rst_n_i (async active-low), bus (id_ex_stage_if.slave).
module id_ex_stage #(
  parameter int         MUL_CYCLES = 3,
  parameter int         DATA_W     = 32,
  parameter logic [2:0] MUL_ALU    = 3'b111
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  id_ex_stage_if.slave   bus
);

  localparam int CNT_W =
    (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MUL_CYCLES - 1);

  logic [4:0]        ex_q;
  logic [1:0]        mem_q;
  logic [1:0]        wb_q;
  logic [DATA_W-1:0] rs_d_q;
  logic [DATA_W-1:0] rt_d_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        rs_a_q;
  logic [4:0]        rt_a_q;
  logic [4:0]        rd_a_q;
  logic [CNT_W-1:0]  cnt_q;

  logic busy;
  logic load_use;
  logic stall;
  logic is_mul;

  assign busy   = (cnt_q != '0);
  assign is_mul = (bus.EX_ctrl_i[4:2] == MUL_ALU);

  // Load in EX whose destination is read by the instruction in ID.
  assign load_use = (mem_q == 2'b10)
                  & (rt_a_q != 5'd0)
                  & ((rt_a_q == bus.rs_addr_i)
                   | (rt_a_q == bus.rt_addr_i));

  assign stall = busy | load_use;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      rs_d_q <= '0;
      rt_d_q <= '0;
      imm_q  <= '0;
      rs_a_q <= '0;
      rt_a_q <= '0;
      rd_a_q <= '0;
      cnt_q  <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q - 1'b1;
    end else if (load_use) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      rs_d_q <= '0;
      rt_d_q <= '0;
      imm_q  <= '0;
      rs_a_q <= '0;
      rt_a_q <= '0;
      rd_a_q <= '0;
    end else begin
      ex_q   <= bus.EX_ctrl_i;
      mem_q  <= bus.MEM_ctrl_i;
      wb_q   <= bus.WB_ctrl_i;
      rs_d_q <= bus.rs_data_i;
      rt_d_q <= bus.rt_data_i;
      imm_q  <= bus.imm_i;
      rs_a_q <= bus.rs_addr_i;
      rt_a_q <= bus.rt_addr_i;
      rd_a_q <= bus.rd_addr_i;
      cnt_q  <= is_mul ? CNT_LOAD : '0;
    end
  end

  assign bus.EX_ctrl_o  = ex_q;
  assign bus.MEM_ctrl_o = mem_q;
  assign bus.WB_ctrl_o  = wb_q;
  assign bus.rs_data_o  = rs_d_q;
  assign bus.rt_data_o  = rt_d_q;
  assign bus.imm_o      = imm_q;
  assign bus.rs_addr_o  = rs_a_q;
  assign bus.rt_addr_o  = rt_a_q;
  assign bus.rd_addr_o  = rd_a_q;
  assign bus.stall_o    = stall;
  assign bus.busy_o     = busy;
  // A stalled cycle must never redirect PC or flush IF/ID.
  assign bus.PC_ctrl_o  = stall ? 2'b00 : bus.PC_ctrl_i;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use, MUL hold, PC gating, reset.
// Two instances: MUL_CYCLES=3 (b3) and MUL_CYCLES=2 (b2).
module tb_id_ex_stage;

  localparam logic [4:0] EX_LW  = 5'b00010;
  localparam logic [4:0] EX_ADD = 5'b00001;
  localparam logic [4:0] EX_MUL = 5'b11101;
  localparam logic [4:0] EX_BEQ = 5'b00100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   pass = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32)) b3 ();
  id_ex_stage_if #(.DATA_W(32)) b2 ();

  id_ex_stage #(.MUL_CYCLES(3), .DATA_W(32)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b3)
  );
  id_ex_stage #(.MUL_CYCLES(2), .DATA_W(32)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b2)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drv3(input logic [1:0] pc, input logic [4:0] ex,
                      input logic [1:0] mem, input logic [1:0] wb,
                      input logic [31:0] rsd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd);
    b3.PC_ctrl_i = pc;  b3.EX_ctrl_i = ex;
    b3.MEM_ctrl_i = mem; b3.WB_ctrl_i = wb;
    b3.rs_data_i = rsd; b3.rt_data_i = rsd ^ 32'hFFFF;
    b3.imm_i = rsd + 32'd4;
    b3.rs_addr_i = rs; b3.rt_addr_i = rt; b3.rd_addr_i = rd;
    #1;
  endtask

  task automatic drv2(input logic [4:0] ex, input logic [31:0] rsd);
    b2.PC_ctrl_i = 2'b00; b2.EX_ctrl_i = ex;
    b2.MEM_ctrl_i = 2'b00; b2.WB_ctrl_i = (ex == 5'd0) ? 2'b00 : 2'b01;
    b2.rs_data_i = rsd; b2.rt_data_i = 32'd0; b2.imm_i = 32'd0;
    b2.rs_addr_i = 5'd1; b2.rt_addr_i = 5'd2; b2.rd_addr_i = 5'd3;
    #1;
  endtask

  task automatic test_reset();
    drv3(2'b00, 5'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    drv2(5'd0, 32'd0);
    rst_n = 1'b0;
    #12;
    total++; if ({b3.EX_ctrl_o, b3.MEM_ctrl_o, b3.WB_ctrl_o} !== 9'd0)
      $display("FAIL reset_ctrl got %h want 0", {b3.EX_ctrl_o, b3.MEM_ctrl_o, b3.WB_ctrl_o}); else pass++;
    total++; if ({b3.rs_data_o, b3.rt_data_o, b3.imm_o} !== 96'd0)
      $display("FAIL reset_data got %h want 0", {b3.rs_data_o, b3.rt_data_o, b3.imm_o}); else pass++;
    total++; if ({b3.busy_o, b3.stall_o, b2.busy_o} !== 3'b000)
      $display("FAIL reset_busy got %b want 000", {b3.busy_o, b3.stall_o, b2.busy_o}); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    edge1();
  endtask

  task automatic test_load_use();
    drv3(2'b00, EX_LW, 2'b10, 2'b11, 32'h100, 5'd1, 5'd5, 5'd0);
    edge1();
    total++; if (b3.MEM_ctrl_o !== 2'b10 || b3.rt_addr_o !== 5'd5)
      $display("FAIL lu_lw_in_ex got %b/%0d want 10/5", b3.MEM_ctrl_o, b3.rt_addr_o); else pass++;
    drv3(2'b00, EX_ADD, 2'b00, 2'b01, 32'h1234, 5'd5, 5'd2, 5'd3);
    total++; if (b3.stall_o !== 1'b1)
      $display("FAIL lu_stall got %b want 1", b3.stall_o); else pass++;
    edge1();
    total++; if ({b3.EX_ctrl_o, b3.MEM_ctrl_o, b3.WB_ctrl_o, b3.rs_data_o, b3.rt_addr_o} !== 46'd0)
      $display("FAIL lu_bubble got %h want 0", {b3.EX_ctrl_o, b3.MEM_ctrl_o, b3.WB_ctrl_o, b3.rs_data_o, b3.rt_addr_o}); else pass++;
    total++; if (b3.stall_o !== 1'b0)
      $display("FAIL lu_one_bubble stall got %b want 0", b3.stall_o); else pass++;
    edge1();
    total++; if (b3.EX_ctrl_o !== EX_ADD || b3.rs_addr_o !== 5'd5 || b3.rd_addr_o !== 5'd3 || b3.rs_data_o !== 32'h1234)
      $display("FAIL lu_add_enter got %h/%0d/%0d/%h want %h/5/3/1234", b3.EX_ctrl_o, b3.rs_addr_o, b3.rd_addr_o, b3.rs_data_o, EX_ADD); else pass++;
  endtask

  task automatic test_lw_r0();
    drv3(2'b00, EX_LW, 2'b10, 2'b11, 32'h200, 5'd0, 5'd0, 5'd0);
    edge1();
    drv3(2'b00, EX_ADD, 2'b00, 2'b01, 32'h55, 5'd0, 5'd0, 5'd4);
    total++; if (b3.stall_o !== 1'b0)
      $display("FAIL r0_stall got %b want 0", b3.stall_o); else pass++;
    edge1();
    total++; if (b3.EX_ctrl_o !== EX_ADD || b3.rs_data_o !== 32'h55)
      $display("FAIL r0_no_bubble got %h/%h want %h/55", b3.EX_ctrl_o, b3.rs_data_o, EX_ADD); else pass++;
  endtask

  task automatic test_beq_gate();
    drv3(2'b00, EX_LW, 2'b10, 2'b11, 32'h300, 5'd1, 5'd7, 5'd0);
    edge1();
    drv3(2'b11, EX_BEQ, 2'b00, 2'b00, 32'h77, 5'd7, 5'd8, 5'd0);
    total++; if (b3.stall_o !== 1'b1 || b3.PC_ctrl_o !== 2'b00)
      $display("FAIL beq_gated got %b/%b want 1/00", b3.stall_o, b3.PC_ctrl_o); else pass++;
    edge1();
    total++; if (b3.PC_ctrl_o !== 2'b11)
      $display("FAIL beq_redirect got %b want 11", b3.PC_ctrl_o); else pass++;
    edge1();
    total++; if (b3.EX_ctrl_o !== EX_BEQ || b3.MEM_ctrl_o !== 2'b00 || b3.WB_ctrl_o !== 2'b00)
      $display("FAIL beq_in_ex got %h/%b/%b want %h/00/00", b3.EX_ctrl_o, b3.MEM_ctrl_o, b3.WB_ctrl_o, EX_BEQ); else pass++;
    drv3(2'b00, 5'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    edge1();
  endtask

  task automatic test_mul_hold();
    drv3(2'b00, EX_MUL, 2'b00, 2'b01, 32'hAAAA, 5'd9, 5'd10, 5'd11);
    edge1();
    total++; if (b3.EX_ctrl_o !== EX_MUL || b3.busy_o !== 1'b1)
      $display("FAIL mul_cap got %h/%b want %h/1", b3.EX_ctrl_o, b3.busy_o, EX_MUL); else pass++;
    drv3(2'b01, EX_ADD, 2'b00, 2'b01, 32'hBBBB, 5'd12, 5'd13, 5'd14);
    total++; if (b3.stall_o !== 1'b1 || b3.PC_ctrl_o !== 2'b00)
      $display("FAIL mul_stall got %b/%b want 1/00", b3.stall_o, b3.PC_ctrl_o); else pass++;
    edge1();
    total++; if (b3.busy_o !== 1'b1 || b3.rs_data_o !== 32'hAAAA || b3.rd_addr_o !== 5'd11)
      $display("FAIL mul_hold2 got %b/%h/%0d want 1/aaaa/11", b3.busy_o, b3.rs_data_o, b3.rd_addr_o); else pass++;
    edge1();
    total++; if (b3.busy_o !== 1'b0 || b3.EX_ctrl_o !== EX_MUL || b3.PC_ctrl_o !== 2'b01)
      $display("FAIL mul_release got %b/%h/%b want 0/%h/01", b3.busy_o, b3.EX_ctrl_o, b3.PC_ctrl_o, EX_MUL); else pass++;
    edge1();
    total++; if (b3.EX_ctrl_o !== EX_ADD || b3.rs_data_o !== 32'hBBBB)
      $display("FAIL mul_next_add got %h/%h want %h/bbbb", b3.EX_ctrl_o, b3.rs_data_o, EX_ADD); else pass++;
  endtask

  task automatic test_reset_mid_mul();
    drv3(2'b00, EX_MUL, 2'b00, 2'b01, 32'hCCCC, 5'd1, 5'd2, 5'd3);
    edge1();
    drv3(2'b00, EX_ADD, 2'b00, 2'b01, 32'hDDDD, 5'd4, 5'd6, 5'd7);
    edge1();
    total++; if (b3.busy_o !== 1'b1)
      $display("FAIL rmul_busy got %b want 1", b3.busy_o); else pass++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (b3.busy_o !== 1'b0 || b3.EX_ctrl_o !== 5'd0 || b3.rs_data_o !== 32'd0 || b3.WB_ctrl_o !== 2'd0)
      $display("FAIL rmul_async got %b/%h/%h/%b want 0/0/0/0", b3.busy_o, b3.EX_ctrl_o, b3.rs_data_o, b3.WB_ctrl_o); else pass++;
    #1 rst_n = 1'b1;
    edge1();
    total++; if (b3.EX_ctrl_o !== EX_ADD || b3.rs_data_o !== 32'hDDDD || b3.busy_o !== 1'b0)
      $display("FAIL rmul_after got %h/%h/%b want %h/dddd/0", b3.EX_ctrl_o, b3.rs_data_o, b3.busy_o, EX_ADD); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [31:0] dat [4];
    drv2(EX_MUL, 32'h1111);
    edge1();
    pat[3] = b2.busy_o; dat[0] = b2.rs_data_o;
    drv2(EX_MUL, 32'h2222);
    edge1();
    pat[2] = b2.busy_o; dat[1] = b2.rs_data_o;
    edge1();
    pat[1] = b2.busy_o; dat[2] = b2.rs_data_o;
    drv2(5'd0, 32'h3333);
    edge1();
    pat[0] = b2.busy_o; dat[3] = b2.rs_data_o;
    total++; if (pat !== 4'b1010)
      $display("FAIL b2b_busy got %b want 1010", pat); else pass++;
    total++; if (dat[0] !== 32'h1111 || dat[1] !== 32'h1111 || dat[2] !== 32'h2222 || dat[3] !== 32'h2222)
      $display("FAIL b2b_occupy got %h %h %h %h want 1111 1111 2222 2222", dat[0], dat[1], dat[2], dat[3]); else pass++;
    edge1();
    total++; if (b2.EX_ctrl_o !== 5'd0 || b2.rs_data_o !== 32'h3333 || b2.busy_o !== 1'b0)
      $display("FAIL b2b_after got %h/%h/%b want 0/3333/0", b2.EX_ctrl_o, b2.rs_data_o, b2.busy_o); else pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lw_r0();
    test_beq_gate();
    test_mul_hold();
    test_reset_mid_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
